// File: rtl/hack_alu.sv
// Hack-architecture ALU: operand conditioning, ripple-carry add or bitwise AND,
// optional result negation; result and zero/negative flags registered with a valid strobe.
`timescale 1ns/1ps

module hack_alu #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             out_valid
);

    logic [WIDTH-1:0] x1, x2, y1, y2;
    logic [WIDTH-1:0] and_r, sum, r, res;
    logic [WIDTH-1:0] carry;

    // Zeroing happens before negation, so a zeroed operand never lets its raw input through.
    assign x1 = zx ? '0 : x;
    assign x2 = nx ? ~x1 : x1;
    assign y1 = zy ? '0 : y;
    assign y2 = ny ? ~y1 : y1;

    assign and_r = x2 & y2;

    // Ripple-carry adder; the carry out of the MSB is never formed since it is discarded.
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i] = x2[i] ^ y2[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (x2[i] & y2[i]) | (carry[i] & (x2[i] ^ y2[i]));
        end
    end

    assign r   = f ? sum : and_r;
    assign res = no ? ~r : r;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out       <= '0;
            zr        <= 1'b1;
            ng        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= res;
                zr  <= (res == '0);
                ng  <= res[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: directed vector table, hold/reset sequences,
// and randomized traffic against an arithmetic reference model.
`timescale 1ns/1ps

module tb_hack_alu;

    typedef struct {
        logic [5:0]  ctl;   // zx nx zy ny f no
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] out;
        logic        zr;
        logic        ng;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        zx = 1'b0, nx = 1'b0, zy = 1'b0, ny = 1'b0, f = 1'b0, no = 1'b0;
    logic [15:0] out;
    logic        zr, ng, out_valid;

    int errors = 0;
    int checks = 0;

    hack_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out(out), .zr(zr), .ng(ng), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        in_valid = v;
        {zx, nx, zy, ny, f, no} = c;
        x = a;
        y = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [15:0] e_out, input logic e_zr,
                             input logic e_ng, input logic e_valid);
        check({name, ".out"}, 32'(out), 32'(e_out));
        check({name, ".zr"}, 32'(zr), 32'(e_zr));
        check({name, ".ng"}, 32'(ng), 32'(e_ng));
        check({name, ".out_valid"}, 32'(out_valid), 32'(e_valid));
    endtask

    // Reference model straight from the control-bit definitions, using integer arithmetic.
    function automatic logic [15:0] ref_alu(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b);
        int unsigned xa, yb, r;
        xa = c[5] ? 0 : int'(a);
        if (c[4]) xa = 65535 - xa;
        yb = c[3] ? 0 : int'(b);
        if (c[2]) yb = 65535 - yb;
        r = c[1] ? (xa + yb) % 65536 : (xa & yb);
        if (c[0]) r = 65535 - r;
        return r[15:0];
    endfunction

    vec_t vecs[21];

    initial begin
        logic [15:0] e_out;
        logic        e_zr, e_ng;
        logic [5:0]  rc;
        logic [15:0] ra, rb;
        logic        rv;

        vecs[0]  = '{6'b101010, 16'h000F, 16'h0003, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{6'b111111, 16'h000F, 16'h0003, 16'h0001, 1'b0, 1'b0};
        vecs[2]  = '{6'b111010, 16'h000F, 16'h0003, 16'hFFFF, 1'b0, 1'b1};
        vecs[3]  = '{6'b001100, 16'h000F, 16'h0003, 16'h000F, 1'b0, 1'b0};
        vecs[4]  = '{6'b110000, 16'h000F, 16'h0003, 16'h0003, 1'b0, 1'b0};
        vecs[5]  = '{6'b001101, 16'h000F, 16'h0003, 16'hFFF0, 1'b0, 1'b1};
        vecs[6]  = '{6'b110001, 16'h000F, 16'h0003, 16'hFFFC, 1'b0, 1'b1};
        vecs[7]  = '{6'b001111, 16'h000F, 16'h0003, 16'hFFF1, 1'b0, 1'b1};
        vecs[8]  = '{6'b110011, 16'h000F, 16'h0003, 16'hFFFD, 1'b0, 1'b1};
        vecs[9]  = '{6'b011111, 16'h000F, 16'h0003, 16'h0010, 1'b0, 1'b0};
        vecs[10] = '{6'b110111, 16'h000F, 16'h0003, 16'h0004, 1'b0, 1'b0};
        vecs[11] = '{6'b001110, 16'h000F, 16'h0003, 16'h000E, 1'b0, 1'b0};
        vecs[12] = '{6'b110010, 16'h000F, 16'h0003, 16'h0002, 1'b0, 1'b0};
        vecs[13] = '{6'b000010, 16'h000F, 16'h0003, 16'h0012, 1'b0, 1'b0};
        vecs[14] = '{6'b010011, 16'h000F, 16'h0003, 16'h000C, 1'b0, 1'b0};
        vecs[15] = '{6'b000111, 16'h000F, 16'h0003, 16'hFFF4, 1'b0, 1'b1};
        vecs[16] = '{6'b000000, 16'h000F, 16'h0003, 16'h0003, 1'b0, 1'b0};
        vecs[17] = '{6'b010101, 16'h000F, 16'h0003, 16'h000F, 1'b0, 1'b0};
        vecs[18] = '{6'b000010, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
        vecs[19] = '{6'b000010, 16'hFFFF, 16'hFFFE, 16'hFFFD, 1'b0, 1'b1};
        vecs[20] = '{6'b000010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};

        // Reset, then idle cycles: reset state must persist until a valid input.
        rst = 1'b1;
        drive(1'b0, 6'b000010, 16'h1234, 16'h4321);
        step();
        check_all("reset", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        step();
        step();
        check_all("reset_hold", 16'h0000, 1'b1, 1'b0, 1'b0);

        // Canonical codes and edge values, back-to-back.
        for (int i = 0; i < 21; i++) begin
            drive(1'b1, vecs[i].ctl, vecs[i].x, vecs[i].y);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].out, vecs[i].zr, vecs[i].ng, 1'b1);
        end

        // Hold: a valid x+y result, then idle with different inputs.
        drive(1'b1, 6'b000010, 16'h0001, 16'h0002);
        step();
        check_all("hold_load", 16'h0003, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 6'b111010, 16'h8888, 16'h9999);
        step();
        check_all("hold_idle", 16'h0003, 1'b0, 1'b0, 1'b0);

        // Reset colliding with a valid input: input dropped, next one processed.
        drive(1'b1, 6'b000010, 16'h0005, 16'h0005);
        rst = 1'b1;
        step();
        check_all("rst_mid", 16'h0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 6'b001110, 16'h0000, 16'hABCD);
        step();
        check_all("post_rst", 16'hFFFF, 1'b0, 1'b1, 1'b1);

        // Randomized traffic with a scoreboard holding the expected registered state.
        e_out = 16'hFFFF;
        e_zr  = 1'b0;
        e_ng  = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            rc = 6'($urandom);
            ra = 16'($urandom);
            rb = 16'($urandom);
            rv = ($urandom_range(0, 9) != 0);
            drive(rv, rc, ra, rb);
            step();
            if (rv) begin
                e_out = ref_alu(rc, ra, rb);
                e_zr  = (e_out == 16'h0000);
                e_ng  = e_out[15];
            end
            check_all($sformatf("rand%0d", n), e_out, e_zr, e_ng, rv);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hack_alu.md
Name: hack_alu

Overview:
Hack-architecture 16-bit ALU for the CPU datapath: two operands, six control bits (zx, nx, zy, ny, f, no), result plus zero/negative flags. Combinational core; result and flags registered, one-cycle latency, valid-qualified. Adder built structurally (ripple or lookahead), not behavioural "+" of the whole function.

Parameters:
WIDTH, 16, operand/result width in bits; flags and control semantics unchanged for other widths.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  x, y and control bits valid this cycle
x  input  WIDTH  operand x (two's complement)
y  input  WIDTH  operand y (two's complement)
zx  input  1  zero x
nx  input  1  bitwise-negate x (after zx)
zy  input  1  zero y
ny  input  1  bitwise-negate y (after zy)
f  input  1  1: add, 0: bitwise AND
no  input  1  bitwise-negate result
out  output  WIDTH  registered result
zr  output  1  registered: out == 0
ng  output  1  registered: out[WIDTH-1]
out_valid  output  1  out/zr/ng updated this cycle

Behaviour:
- Combinational pipeline, strict order: x1 = zx ? 0 : x; x2 = nx ? ~x1 : x1; same for y with zy/ny; r = f ? (x2 + y2) mod 2^WIDTH : (x2 & y2); res = no ? ~r : r.
- Addition modulo 2^WIDTH; carry-out discarded; no overflow flag (0x7FFF + 1 = 0x8000, ng=1).
- zr = 1 iff res is all zeros; ng = res MSB. Flags derived from final res (after no), never from r.
- Rising edge with rst=1: out=0, zr=1, ng=0, out_valid=0; rst wins over in_valid.
- Edge with rst=0, in_valid=1: out<=res, zr/ng<=flags of res, out_valid<=1. Latency exactly one cycle; back-to-back valid inputs give one result per cycle.
- Edge with rst=0, in_valid=0: out/zr/ng hold previous values; out_valid<=0.
- Reset asserted mid-stream: pending input dropped, no result produced for that cycle.
- All 64 control combinations legal; the 18 canonical codes (zx nx zy ny f no): 0=101010, 1=111111, -1=111010, x=001100, y=110000, !x=001101, !y=110001, -x=001111, -y=110011, x+1=011111, y+1=110111, x-1=001110, y-1=110010, x+y=000010, x-y=010011, y-x=000111, x&y=000000, x|y=010101.
- No X propagation from unused operand: zeroed operand ignored regardless of input value.

Test Plan:
- Reset: rst=1 one edge -> out=0000, zr=1, ng=0, out_valid=0; holds until first valid input.
- x=000F, y=0003, sweep all 18 canonical codes back-to-back with in_valid=1 -> next-cycle out: 0000(zr=1),0001,FFFF(ng=1),000F,0003,FFF0,FFFC,FFF1,FFFD,0010,0004,000E,0002,0012,000C,FFF4(ng=1),0003,000F; out_valid=1 each cycle.
- Edge values with 000010: x=y=0000 -> 0000 zr=1 ng=0; x=FFFF,y=FFFE -> FFFD ng=1; x=7FFF,y=0001 -> 8000 zr=0 ng=1.
- Hold: valid x+y result, then in_valid=0 with changed x/y/controls -> out/zr/ng unchanged, out_valid=0.
- Reset mid-stream: in_valid=1 and rst=1 same edge -> out=0000, zr=1, out_valid=0; next valid input processed normally.
- Random: 10k random x, y, control bits vs. reference model -> exact match of out, zr, ng one cycle later.
